arm_multicycle_ctrl: RTL and testbench



---
 rtl/arm_ctrl_pkg.sv | 69 ++++++
 rtl/arm_multicycle_ctrl_classify.sv | 40 ++++
 rtl/arm_multicycle_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_arm_multicycle_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_ctrl_pkg.sv
// Shared types, encodings and the ARM condition evaluator for the multi-cycle controller.
package arm_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH    = 3'd0,
        ST_DECODE   = 3'd1,
        ST_EXEC     = 3'd2,
        ST_MUL_WAIT = 3'd3,
        ST_MEM      = 3'd4,
        ST_WB       = 3'd5,
        ST_BRANCH   = 3'd6
    } state_e;

    localparam logic [1:0] INS_UNK = 2'd0;
    localparam logic [1:0] INS_DP  = 2'd1;
    localparam logic [1:0] INS_MEM = 2'd2;
    localparam logic [1:0] INS_BR  = 2'd3;

    localparam logic [2:0] DP_UNK = 3'd0;
    localparam logic [2:0] DP_IMM = 3'd1;
    localparam logic [2:0] DP_RSV = 3'd2;
    localparam logic [2:0] DP_RSR = 3'd3;
    localparam logic [2:0] DP_MUL = 3'd4;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    // nzcv is ordered {N, Z, C, V}; NV is treated as never executing.
    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v;
        n = nzcv[3];
        z = nzcv[2];
        c = nzcv[1];
        v = nzcv[0];
        case (cond)
            COND_EQ: cond_pass = z;
            COND_NE: cond_pass = ~z;
            COND_CS: cond_pass = c;
            COND_CC: cond_pass = ~c;
            COND_MI: cond_pass = n;
            COND_PL: cond_pass = ~n;
            COND_VS: cond_pass = v;
            COND_VC: cond_pass = ~v;
            COND_HI: cond_pass = c & ~z;
            COND_LS: cond_pass = ~c | z;
            COND_GE: cond_pass = (n == v);
            COND_LT: cond_pass = (n != v);
            COND_GT: cond_pass = ~z & (n == v);
            COND_LE: cond_pass = z | (n != v);
            COND_AL: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/arm_multicycle_ctrl_classify.sv
// Combinational instruction classifier: ir -> {instruction class, data-processing subtype}.
module arm_ins_classify
    import arm_ctrl_pkg::*;
(
    input  logic [31:0] ir_i,
    output logic [1:0]  ins_type_o,
    output logic [2:0]  data_ins_type_o
);

    logic unused_ir_s;
    assign unused_ir_s = ^{ir_i[31:28], ir_i[23:8], ir_i[3:0]};

    // Class from ir[27:26]; subtype only meaningful for data-processing.
    always_comb begin
        ins_type_o      = INS_UNK;
        data_ins_type_o = DP_UNK;
        case (ir_i[27:26])
            2'b00:   ins_type_o = INS_DP;
            2'b01:   ins_type_o = INS_MEM;
            2'b10:   ins_type_o = INS_BR;
            default: ins_type_o = INS_UNK;
        endcase
        if (ir_i[27:26] == 2'b00) begin
            if (ir_i[25]) begin
                data_ins_type_o = DP_IMM;
            end else if (!ir_i[4]) begin
                data_ins_type_o = DP_RSV;
            end else if (!ir_i[7]) begin
                data_ins_type_o = DP_RSR;
            end else if (!ir_i[24] && (ir_i[6:5] == 2'b00)) begin
                data_ins_type_o = DP_MUL;
            end else begin
                data_ins_type_o = DP_UNK;
            end
        end else begin
            data_ins_type_o = DP_UNK;
        end
    end

endmodule

// File: rtl/arm_multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MUL_WAIT/MEM/WB/BRANCH sequencer for the ARM-subset core.
// Optional macro ARM_CTRL_COND_CHECK_EN enables condition-code evaluation in DECODE.
module arm_multicycle_ctrl
    import arm_ctrl_pkg::*;
#(
    parameter int MUL_TIMEOUT = 16
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [31:0] instr_in_i,
    input  logic        imem_ready_i,
    output logic        imem_req_o,
    input  logic [3:0]  flags_nzcv_i,
    input  logic        mul_done_i,
    input  logic        dmem_ready_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] ir_o,
    output logic [1:0]  ins_type_o,
    output logic [2:0]  data_ins_type_o,
    output logic        alu_en_o,
    output logic        mul_start_o,
    output logic        rf_we_o,
    output logic        lr_we_o,
    output logic        pc_we_o,
    output logic        pc_sel_o,
    output logic        illegal_instr_o,
    output logic [2:0]  state_dbg_o
);

    localparam logic [15:0] MUL_TO = 16'(MUL_TIMEOUT);

    state_e      state_q, state_d;
    logic [31:0] ir_q, ir_d;
    logic [1:0]  ins_type_q, ins_type_d;
    logic [2:0]  dp_type_q, dp_type_d;
    logic [15:0] mul_cnt_q, mul_cnt_d;

    logic [1:0]  cls_s;
    logic [2:0]  sub_s;
    logic        cond_ok_s;

    logic imem_req_s, dmem_req_s, dmem_we_s, alu_en_s, mul_start_s;
    logic rf_we_s, lr_we_s, pc_we_s, pc_sel_s, illegal_s;

    arm_ins_classify u_classify (
        .ir_i            (ir_q),
        .ins_type_o      (cls_s),
        .data_ins_type_o (sub_s)
    );

`ifdef ARM_CTRL_COND_CHECK_EN
    assign cond_ok_s = cond_pass(ir_q[31:28], flags_nzcv_i);
`else
    logic unused_flags_s;
    assign unused_flags_s = ^flags_nzcv_i;
    assign cond_ok_s      = 1'b1;
`endif

    // Next-state and strobe decode from the registered state.
    always_comb begin
        state_d     = state_q;
        ir_d        = ir_q;
        ins_type_d  = ins_type_q;
        dp_type_d   = dp_type_q;
        mul_cnt_d   = mul_cnt_q;
        imem_req_s  = 1'b0;
        dmem_req_s  = 1'b0;
        dmem_we_s   = 1'b0;
        alu_en_s    = 1'b0;
        mul_start_s = 1'b0;
        rf_we_s     = 1'b0;
        lr_we_s     = 1'b0;
        pc_we_s     = 1'b0;
        pc_sel_s    = 1'b0;
        illegal_s   = 1'b0;
        case (state_q)
            ST_FETCH: begin
                imem_req_s = 1'b1;
                if (imem_ready_i) begin
                    ir_d    = instr_in_i;
                    pc_we_s = 1'b1;
                    state_d = ST_DECODE;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_DECODE: begin
                ins_type_d = cls_s;
                dp_type_d  = sub_s;
                mul_cnt_d  = 16'd1;
                if (!cond_ok_s) begin
                    state_d = ST_FETCH;
                end else if ((cls_s == INS_UNK) || ((cls_s == INS_DP) && (sub_s == DP_UNK))) begin
                    illegal_s = 1'b1;
                    state_d   = ST_FETCH;
                end else begin
                    case (cls_s)
                        INS_DP:  state_d = (sub_s == DP_MUL) ? ST_MUL_WAIT : ST_EXEC;
                        INS_MEM: state_d = ST_MEM;
                        INS_BR:  state_d = ST_BRANCH;
                        default: state_d = ST_FETCH;
                    endcase
                end
            end
            ST_EXEC: begin
                alu_en_s = 1'b1;
                state_d  = ST_WB;
            end
            ST_MUL_WAIT: begin
                // mul_cnt_q is the 1-based cycle number within MUL_WAIT.
                mul_start_s = (mul_cnt_q == 16'd1);
                if (mul_done_i) begin
                    state_d = ST_WB;
                end else if ((MUL_TO != 16'd0) && (mul_cnt_q == MUL_TO)) begin
                    illegal_s = 1'b1;
                    state_d   = ST_FETCH;
                end else if (mul_cnt_q != 16'hFFFF) begin
                    mul_cnt_d = mul_cnt_q + 16'd1;
                end else begin
                    mul_cnt_d = mul_cnt_q;
                end
            end
            ST_MEM: begin
                dmem_req_s = 1'b1;
                dmem_we_s  = ~ir_q[20];
                if (dmem_ready_i) begin
                    state_d = ir_q[20] ? ST_WB : ST_FETCH;
                end else begin
                    state_d = ST_MEM;
                end
            end
            ST_WB: begin
                rf_we_s = !((ins_type_q == INS_DP) && (ir_q[24:23] == 2'b10));
                state_d = ST_FETCH;
            end
            ST_BRANCH: begin
                pc_we_s  = 1'b1;
                pc_sel_s = 1'b1;
                lr_we_s  = ir_q[24];
                state_d  = ST_FETCH;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    // State, instruction register and decode results.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= ST_FETCH;
            ir_q       <= 32'd0;
            ins_type_q <= INS_UNK;
            dp_type_q  <= DP_UNK;
            mul_cnt_q  <= 16'd0;
        end else begin
            state_q    <= state_d;
            ir_q       <= ir_d;
            ins_type_q <= ins_type_d;
            dp_type_q  <= dp_type_d;
            mul_cnt_q  <= mul_cnt_d;
        end
    end

    // Strobes are held low for as long as reset is asserted.
    assign imem_req_o      = imem_req_s  & ~reset_i;
    assign dmem_req_o      = dmem_req_s  & ~reset_i;
    assign dmem_we_o       = dmem_we_s   & ~reset_i;
    assign alu_en_o        = alu_en_s    & ~reset_i;
    assign mul_start_o     = mul_start_s & ~reset_i;
    assign rf_we_o         = rf_we_s     & ~reset_i;
    assign lr_we_o         = lr_we_s     & ~reset_i;
    assign pc_we_o         = pc_we_s     & ~reset_i;
    assign pc_sel_o        = pc_sel_s    & ~reset_i;
    assign illegal_instr_o = illegal_s   & ~reset_i;
    assign ir_o            = ir_q;
    assign ins_type_o      = ins_type_q;
    assign data_ins_type_o = dp_type_q;
    assign state_dbg_o     = state_q;

endmodule

// File: tb/tb_arm_multicycle_ctrl.sv
// Directed self-checking bench for arm_multicycle_ctrl.
module tb_arm_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr_in;
    logic        imem_ready;
    logic        imem_req;
    logic [3:0]  flags_nzcv;
    logic        mul_done;
    logic        dmem_ready;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] ir;
    logic [1:0]  ins_type;
    logic [2:0]  data_ins_type;
    logic        alu_en;
    logic        mul_start;
    logic        rf_we;
    logic        lr_we;
    logic        pc_we;
    logic        pc_sel;
    logic        illegal_instr;
    logic [2:0]  state_dbg;

    int n_cmp = 0;
    int n_err = 0;

    arm_multicycle_ctrl #(.MUL_TIMEOUT(16)) dut (
        .clk_i           (clk),
        .reset_i         (reset),
        .instr_in_i      (instr_in),
        .imem_ready_i    (imem_ready),
        .imem_req_o      (imem_req),
        .flags_nzcv_i    (flags_nzcv),
        .mul_done_i      (mul_done),
        .dmem_ready_i    (dmem_ready),
        .dmem_req_o      (dmem_req),
        .dmem_we_o       (dmem_we),
        .ir_o            (ir),
        .ins_type_o      (ins_type),
        .data_ins_type_o (data_ins_type),
        .alu_en_o        (alu_en),
        .mul_start_o     (mul_start),
        .rf_we_o         (rf_we),
        .lr_we_o         (lr_we),
        .pc_we_o         (pc_we),
        .pc_sel_o        (pc_sel),
        .illegal_instr_o (illegal_instr),
        .state_dbg_o     (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction in FETCH, confirm the fetch strobes, advance into DECODE.
    task automatic fetch(input logic [31:0] word);
        check_eq("fetch_state", {29'd0, state_dbg}, 32'd0);
        instr_in   = word;
        imem_ready = 1'b1;
        #1;
        check_eq("fetch_imem_req", {31'd0, imem_req}, 32'd1);
        check_eq("fetch_pc_we", {31'd0, pc_we}, 32'd1);
        check_eq("fetch_pc_sel", {31'd0, pc_sel}, 32'd0);
        step();
        imem_ready = 1'b0;
        check_eq("decode_state", {29'd0, state_dbg}, 32'd1);
        check_eq("decode_ir", ir, word);
    endtask

    initial begin
        reset = 1'b1; instr_in = 32'd0; imem_ready = 1'b0; flags_nzcv = 4'd0;
        mul_done = 1'b0; dmem_ready = 1'b0;
        step(); step();
        check_eq("rst_state", {29'd0, state_dbg}, 32'd0);
        check_eq("rst_ir", ir, 32'd0);
        check_eq("rst_ins_type", {30'd0, ins_type}, 32'd0);
        check_eq("rst_dp_type", {29'd0, data_ins_type}, 32'd0);
        check_eq("rst_strobes", {22'd0, imem_req, dmem_req, dmem_we, alu_en, mul_start,
                                 rf_we, lr_we, pc_we, pc_sel, illegal_instr}, 32'd0);
        // imem_ready together with reset: reset wins, ir stays 0
        instr_in = 32'hE2811001; imem_ready = 1'b1;
        step();
        check_eq("rst_vs_fetch_ir", ir, 32'd0);
        check_eq("rst_vs_fetch_state", {29'd0, state_dbg}, 32'd0);
        imem_ready = 1'b0;
        reset = 1'b0;
        #1;

        // ADD immediate
        fetch(32'hE2811001);
        check_eq("add_decode_illegal", {31'd0, illegal_instr}, 32'd0);
        step();
        check_eq("add_exec_state", {29'd0, state_dbg}, 32'd2);
        check_eq("add_alu_en", {31'd0, alu_en}, 32'd1);
        check_eq("add_ins_type", {30'd0, ins_type}, 32'd1);
        check_eq("add_dp_type", {29'd0, data_ins_type}, 32'd1);
        step();
        check_eq("add_wb_state", {29'd0, state_dbg}, 32'd5);
        check_eq("add_rf_we", {31'd0, rf_we}, 32'd1);
        check_eq("add_wb_alu_en", {31'd0, alu_en}, 32'd0);
        step();
        check_eq("add_back_fetch", {29'd0, state_dbg}, 32'd0);

        // LDR with 3-cycle dmem delay
        fetch(32'hE5912000);
        step();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) dmem_ready = 1'b1;
            #1;
            check_eq("ldr_dmem_req", {31'd0, dmem_req}, 32'd1);
            check_eq("ldr_dmem_we", {31'd0, dmem_we}, 32'd0);
            check_eq("ldr_mem_state", {29'd0, state_dbg}, 32'd4);
            step();
        end
        dmem_ready = 1'b0;
        check_eq("ldr_wb_state", {29'd0, state_dbg}, 32'd5);
        check_eq("ldr_rf_we", {31'd0, rf_we}, 32'd1);
        check_eq("ldr_ins_type", {30'd0, ins_type}, 32'd2);
        check_eq("ldr_wb_dmem_req", {31'd0, dmem_req}, 32'd0);
        step();

        // STR, zero-wait
        fetch(32'hE5812000);
        step();
        dmem_ready = 1'b1;
        #1;
        check_eq("str_dmem_req", {31'd0, dmem_req}, 32'd1);
        check_eq("str_dmem_we", {31'd0, dmem_we}, 32'd1);
        step();
        dmem_ready = 1'b0;
        check_eq("str_to_fetch", {29'd0, state_dbg}, 32'd0);
        check_eq("str_no_rf_we", {31'd0, rf_we}, 32'd0);

        // BL then B
        fetch(32'hEB000004);
        step();
        check_eq("bl_state", {29'd0, state_dbg}, 32'd6);
        check_eq("bl_pc_we", {31'd0, pc_we}, 32'd1);
        check_eq("bl_pc_sel", {31'd0, pc_sel}, 32'd1);
        check_eq("bl_lr_we", {31'd0, lr_we}, 32'd1);
        check_eq("bl_ins_type", {30'd0, ins_type}, 32'd3);
        step();
        fetch(32'hEA000004);
        step();
        check_eq("b_pc_sel", {31'd0, pc_sel}, 32'd1);
        check_eq("b_lr_we", {31'd0, lr_we}, 32'd0);
        step();

        // MUL with mul_done in the 5th wait cycle
        fetch(32'hE0010392);
        step();
        check_eq("mul_state", {29'd0, state_dbg}, 32'd3);
        check_eq("mul_start_first", {31'd0, mul_start}, 32'd1);
        check_eq("mul_dp_type", {29'd0, data_ins_type}, 32'd4);
        for (int i = 2; i <= 5; i++) begin
            step();
            if (i == 5) mul_done = 1'b1;
            #1;
            check_eq("mul_start_once", {31'd0, mul_start}, 32'd0);
            check_eq("mul_wait_state", {29'd0, state_dbg}, 32'd3);
        end
        step();
        mul_done = 1'b0;
        check_eq("mul_wb_state", {29'd0, state_dbg}, 32'd5);
        check_eq("mul_rf_we", {31'd0, rf_we}, 32'd1);
        step();

        // MUL with mul_done in the first wait cycle
        fetch(32'hE0010392);
        step();
        mul_done = 1'b1;
        #1;
        check_eq("mul_fast_start", {31'd0, mul_start}, 32'd1);
        step();
        mul_done = 1'b0;
        check_eq("mul_fast_wb", {29'd0, state_dbg}, 32'd5);
        step();

        // MUL timeout after 16 cycles
        fetch(32'hE0010392);
        step();
        for (int i = 1; i <= 16; i++) begin
            check_eq("mul_to_illegal", {31'd0, illegal_instr}, (i == 16) ? 32'd1 : 32'd0);
            check_eq("mul_to_state", {29'd0, state_dbg}, 32'd3);
            step();
        end
        check_eq("mul_to_fetch", {29'd0, state_dbg}, 32'd0);
        check_eq("mul_to_no_rf_we", {31'd0, rf_we}, 32'd0);

        // Unknown class
        fetch(32'hEC000000);
        check_eq("unk_illegal", {31'd0, illegal_instr}, 32'd1);
        check_eq("unk_no_strobes", {27'd0, alu_en, mul_start, dmem_req, pc_we, rf_we}, 32'd0);
        step();
        check_eq("unk_to_fetch", {29'd0, state_dbg}, 32'd0);
        check_eq("unk_illegal_drop", {31'd0, illegal_instr}, 32'd0);

        // CMP: writeback suppressed
        fetch(32'hE3510000);
        step();
        check_eq("cmp_alu_en", {31'd0, alu_en}, 32'd1);
        step();
        check_eq("cmp_wb_state", {29'd0, state_dbg}, 32'd5);
        check_eq("cmp_rf_we", {31'd0, rf_we}, 32'd0);
        step();

`ifdef ARM_CTRL_COND_CHECK_EN
        flags_nzcv = 4'b0000;
        fetch(32'h02811001);
        check_eq("eq_skip_illegal", {31'd0, illegal_instr}, 32'd0);
        step();
        check_eq("eq_skip_state", {29'd0, state_dbg}, 32'd0);
        check_eq("eq_skip_ins_type", {30'd0, ins_type}, 32'd1);
        flags_nzcv = 4'b0100;
        fetch(32'h02811001);
        step();
        check_eq("eq_exec_state", {29'd0, state_dbg}, 32'd2);
        step(); step();
        flags_nzcv = 4'b0000;
`endif

        // Reset during MEM abandons the access
        fetch(32'hE5912000);
        step();
        check_eq("rstmem_req_before", {31'd0, dmem_req}, 32'd1);
        reset = 1'b1;
        step();
        check_eq("rstmem_dmem_req", {31'd0, dmem_req}, 32'd0);
        check_eq("rstmem_state", {29'd0, state_dbg}, 32'd0);
        check_eq("rstmem_ir", ir, 32'd0);
        reset = 1'b0;
        #1;
        check_eq("rstmem_dmem_req_after", {31'd0, dmem_req}, 32'd0);
        check_eq("rstmem_imem_req_after", {31'd0, imem_req}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
